tune_sequencer: RTL and testbench

Pattern sequencer feeding the audio synthesis core. Steps through a 16-entry, run-time-writable pattern memory at a fixed tempo and drives the four note gates and the drum trigger with the required level/pulse shapes. Guarantees a release gap between steps so that repeated notes and drum hits retrigger cleanly. Sits between user controls (switches/buttons or a CPU write port) and the `note_*` / `run_drum` inputs of the synthesizer.

---
 rtl/tune_sequencer.sv | 151 +++++++++++++++
 tb/tb_tune_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tune_sequencer.sv
// Pattern sequencer: steps a 16-entry pattern into note gates and drum pulse.
// Define TUNE_SEQ_DEFAULT_PATTERN_EN to load a C-D-E-F pattern at reset.
module tune_sequencer #(
  parameter int STEP_TICKS       = 25_000_000,
  parameter int GAP_TICKS        = 1_000_000,
  parameter int DRUM_PULSE_TICKS = 20_000,
  parameter int NUM_STEPS        = 16
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  input  logic       pat_we,
  input  logic [3:0] pat_addr,
  input  logic [4:0] pat_data,
  output logic       note_c6,
  output logic       note_d6,
  output logic       note_e6,
  output logic       note_f6,
  output logic       run_drum,
  output logic       busy,
  output logic [3:0] step_idx
);

  localparam int TW =
    (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [TW-1:0] HOLD_END =
    TW'(STEP_TICKS - GAP_TICKS - 1);
  localparam logic [TW-1:0] STEP_END =
    TW'(STEP_TICKS - 1);
  localparam logic [3:0] LAST = 4'(NUM_STEPS - 1);
  localparam logic DRUM_ON = (DRUM_PULSE_TICKS > 0);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [3:0]      step_q, step_d;
  logic [4:0]      lat_q, lat_d;
  logic [3:0]      gate_q, gate_d;
  logic            drum_q, drum_d;
  logic            busy_q;
  logic            enter;
  logic [3:0]      enter_step;
  logic [4:0]      pat [16];

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q + 1'b1;
    step_d     = step_q;
    lat_d      = lat_q;
    gate_d     = gate_q;
    drum_d     = 1'b0;
    enter      = 1'b0;
    enter_step = '0;
    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        if (start) enter = 1'b1;
      end
      HOLD: begin
        if (tick_q == HOLD_END) begin
          state_d = GAP;
          gate_d  = '0;
        end else begin
          drum_d = lat_q[4] &&
            (32'(tick_d) < DRUM_PULSE_TICKS);
        end
      end
      GAP: begin
        if (tick_q == STEP_END) begin
          if (step_q != LAST) begin
            enter      = 1'b1;
            enter_step = step_q + 1'b1;
          end else if (loop_en) begin
            enter = 1'b1;
          end else begin
            state_d = IDLE;
            tick_d  = '0;
            step_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Gates and drum bit are latched here so later writes wait for re-entry
    if (enter) begin
      state_d = HOLD;
      tick_d  = '0;
      step_d  = enter_step;
      lat_d   = pat[enter_step];
      gate_d  = pat[enter_step][3:0];
      drum_d  = pat[enter_step][4] && DRUM_ON;
    end
    if (stop) begin
      state_d = IDLE;
      tick_d  = '0;
      step_d  = '0;
      gate_d  = '0;
      drum_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= IDLE;
      tick_q  <= '0;
      step_q  <= '0;
      lat_q   <= '0;
      gate_q  <= '0;
      drum_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      step_q  <= step_d;
      lat_q   <= lat_d;
      gate_q  <= gate_d;
      drum_q  <= drum_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < 16; i++) begin
`ifdef TUNE_SEQ_DEFAULT_PATTERN_EN
        pat[i] <= {(i % 4 == 0), 4'(1 << (i % 4))};
`else
        pat[i] <= '0;
`endif
      end
    end else if (pat_we) begin
      pat[pat_addr] <= pat_data;
    end
  end

  assign note_c6  = gate_q[0];
  assign note_d6  = gate_q[1];
  assign note_e6  = gate_q[2];
  assign note_f6  = gate_q[3];
  assign run_drum = drum_q;
  assign busy     = busy_q;
  assign step_idx = step_q;

endmodule

// File: tb/tb_tune_sequencer.sv
// Scoreboard bench for tune_sequencer with short test timing.
// Expected {busy,step,drum,gates} per cycle are queued by the stimulus.
module tb_tune_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic       pat_we = 1'b0;
  logic [3:0] pat_addr = '0;
  logic [4:0] pat_data = '0;
  logic       note_c6, note_d6, note_e6, note_f6;
  logic       run_drum, busy;
  logic [3:0] step_idx;

  tune_sequencer #(
    .STEP_TICKS      (100),
    .GAP_TICKS       (10),
    .DRUM_PULSE_TICKS(20),
    .NUM_STEPS       (4)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .pat_we    (pat_we),
    .pat_addr  (pat_addr),
    .pat_data  (pat_data),
    .note_c6   (note_c6),
    .note_d6   (note_d6),
    .note_e6   (note_e6),
    .note_f6   (note_f6),
    .run_drum  (run_drum),
    .busy      (busy),
    .step_idx  (step_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [9:0] v;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t em;
  int   errors = 0;
  int   checks = 0;
  int   n = 0;
  logic [9:0] act;

  localparam logic [9:0] Z = '0;

  function automatic logic [9:0] ev(int b, int s, int d, int g);
    return {b[0], s[3:0], d[0], g[3:0]};
  endfunction

  task automatic exp_at(int t, logic [9:0] v, string name);
    sb.push_back('{n + t, v, name});
  endtask

  always @(negedge clk) begin
    act = {busy, step_idx, run_drum,
           note_f6, note_e6, note_d6, note_c6};
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      em = sb.pop_front();
      checks++;
      if (em.at != cyc || act !== em.v) begin
        errors++;
        $display("FAIL %s cyc=%0d want_cyc=%0d got=%b exp=%b",
                 em.name, cyc, em.at, act, em.v);
      end
    end
  end

  task automatic wait_rel(int t);
    while (cyc < n + t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(logic with_stop);
    @(negedge clk);
    start = 1'b1;
    stop  = with_stop;
    n = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic stop_at(int t);
    wait_rel(t - 1);
    @(negedge clk);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
  endtask

  task automatic start_at(int t);
    wait_rel(t - 1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wr(int a, int d);
    @(negedge clk);
    pat_we   = 1'b1;
    pat_addr = a[3:0];
    pat_data = d[4:0];
    @(posedge clk);
    #1;
    pat_we = 1'b0;
  endtask

  task automatic load4(int a, int b, int c, int d);
    wr(0, a);
    wr(1, b);
    wr(2, c);
    wr(3, d);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = cyc + 1;
    exp_at(0, Z, "reset_state");
    exp_at(5, Z, "reset_idle");
    wait_rel(6);

    go(1'b0);
`ifdef TUNE_SEQ_DEFAULT_PATTERN_EN
    exp_at(0,   ev(1, 0, 1, 4'b0001), "dflt_c");
    exp_at(100, ev(1, 1, 0, 4'b0010), "dflt_d");
    exp_at(200, ev(1, 2, 0, 4'b0100), "dflt_e");
    exp_at(300, ev(1, 3, 0, 4'b1000), "dflt_f");
`else
    exp_at(0,   ev(1, 0, 0, 0), "clr_s0");
    exp_at(200, ev(1, 2, 0, 0), "clr_s2");
`endif
    exp_at(400, Z, "dflt_end");
    wait_rel(405);

    load4(5'h11, 5'h02, 5'h04, 5'h18);
    loop_en = 1'b0;
    go(1'b0);
    exp_at(0,   ev(1, 0, 1, 4'b0001), "p_s0_start");
    exp_at(19,  ev(1, 0, 1, 4'b0001), "p_drum_last");
    exp_at(20,  ev(1, 0, 0, 4'b0001), "p_drum_off");
    exp_at(89,  ev(1, 0, 0, 4'b0001), "p_c_last");
    exp_at(90,  ev(1, 0, 0, 0),       "p_gap0");
    exp_at(99,  ev(1, 0, 0, 0),       "p_gap0_end");
    exp_at(100, ev(1, 1, 0, 4'b0010), "p_s1");
    exp_at(189, ev(1, 1, 0, 4'b0010), "p_d_last");
    exp_at(190, ev(1, 1, 0, 0),       "p_gap1");
    exp_at(200, ev(1, 2, 0, 4'b0100), "p_s2");
    exp_at(300, ev(1, 3, 1, 4'b1000), "p_s3");
    exp_at(319, ev(1, 3, 1, 4'b1000), "p_s3_drum");
    exp_at(320, ev(1, 3, 0, 4'b1000), "p_s3_drumoff");
    exp_at(389, ev(1, 3, 0, 4'b1000), "p_f_last");
    exp_at(390, ev(1, 3, 0, 0),       "p_gap3");
    exp_at(399, ev(1, 3, 0, 0),       "p_last_cyc");
    exp_at(400, Z,                    "p_busy_low");
    exp_at(450, Z,                    "p_stays_idle");
    wait_rel(451);

    loop_en = 1'b1;
    go(1'b0);
    exp_at(0,   ev(1, 0, 1, 4'b0001), "l_s0");
    exp_at(150, ev(1, 1, 0, 4'b0010), "l_wr_no_effect");
    exp_at(399, ev(1, 3, 0, 0),       "l_pre_wrap");
    exp_at(400, ev(1, 0, 1, 4'b0001), "l_wrap");
    exp_at(500, ev(1, 1, 0, 4'b1000), "l_new_val");
    exp_at(549, ev(1, 1, 0, 4'b1000), "l_pre_stop");
    exp_at(550, Z,                    "l_stop");
    exp_at(560, Z,                    "l_stop_hold");
    wait_rel(119);
    wr(1, 5'h08);
    stop_at(550);
    loop_en = 1'b0;
    wait_rel(561);
    wr(1, 5'h02);

    go(1'b0);
    exp_at(149, ev(1, 1, 0, 4'b0010), "s_pre");
    exp_at(150, Z,                    "s_stop");
    exp_at(250, Z,                    "s_no_resume");
    stop_at(150);
    wait_rel(251);
    go(1'b0);
    exp_at(0,   ev(1, 0, 1, 4'b0001), "s_restart");
    exp_at(100, ev(1, 1, 0, 4'b0010), "s_restart_s1");
    exp_at(400, Z,                    "s_restart_end");
    wait_rel(401);

    go(1'b1);
    checks++;
    if (busy !== 1'b0 || step_idx !== 4'd0) begin
      errors++;
      $display("FAIL ss_direct busy=%b step=%0d",
               busy, step_idx);
    end
    exp_at(0, Z, "ss_idle");
    exp_at(5, Z, "ss_idle_later");
    wait_rel(6);

    go(1'b0);
    exp_at(0,   ev(1, 0, 1, 4'b0001), "rs_s0");
    exp_at(51,  ev(1, 0, 0, 4'b0001), "rs_after");
    exp_at(90,  ev(1, 0, 0, 0),       "rs_gap");
    exp_at(100, ev(1, 1, 0, 4'b0010), "rs_s1");
    exp_at(400, Z,                    "rs_end");
    start_at(50);
    wait_rel(401);

    load4(5'h01, 5'h01, 5'h01, 5'h01);
    go(1'b0);
    exp_at(89,  ev(1, 0, 0, 4'b0001), "c_hi89");
    exp_at(90,  ev(1, 0, 0, 0),       "c_lo90");
    exp_at(99,  ev(1, 0, 0, 0),       "c_lo99");
    exp_at(100, ev(1, 1, 0, 4'b0001), "c_hi100");
    exp_at(189, ev(1, 1, 0, 4'b0001), "c_hi189");
    exp_at(190, ev(1, 1, 0, 0),       "c_lo190");
    exp_at(199, ev(1, 1, 0, 0),       "c_lo199");
    exp_at(200, ev(1, 2, 0, 4'b0001), "c_hi200");
    wait_rel(401);

    load4(5'h11, 5'h02, 5'h04, 5'h18);
    go(1'b0);
    exp_at(49,  ev(1, 0, 0, 4'b0001), "r_pre");
    exp_at(50,  Z,                    "r_async");
    exp_at(60,  Z,                    "r_released");
    exp_at(150, Z,                    "r_no_resume");
    wait_rel(50);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, step_idx, run_drum, note_f6, note_e6,
         note_d6, note_c6} !== Z) begin
      errors++;
      $display("FAIL r_async_direct");
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_rel(151);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL r_busy_direct busy=%b", busy);
    end

    for (int i = 0; i < 1000 && sb.size() > 0; i++)
      @(posedge clk);
    while (sb.size() > 0) begin
      em = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never sampled want_cyc=%0d", em.name, em.at);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
